// File: rtl/spi_adc_scan_if.sv
// Signal bundle between the multi-channel SPI ADC scanner, the ADC pins and
// the control/measurement logic. The slave modport is the scanner's view.
interface spi_adc_scan_if #(
  parameter int NUM_CH    = 2,
  parameter int DATA_BITS = 12
);
  logic                          start;
  logic                          cont;
  logic                          recalibrate;
  logic [NUM_CH-1:0]             sdo;
  logic                          sclk;
  logic                          cs_n;
  logic [NUM_CH*DATA_BITS-1:0]   data;
  logic                          valid;
  logic                          busy;
  logic                          calibrating;
  logic                          overrun;

  modport master (
    output start, cont, recalibrate, sdo,
    input  sclk, cs_n, data, valid, busy, calibrating, overrun
  );

  modport slave (
    input  start, cont, recalibrate, sdo,
    output sclk, cs_n, data, valid, busy, calibrating, overrun
  );
endinterface

// File: rtl/spi_adc_scan.sv
// Multi-channel SPI ADC scanner: one shared SCLK/CS_n pair, one SDO per ADC,
// all channels captured in parallel. Handles calibration frames, single-shot
// and continuous conversions. SCLK is a registered output paced by a divider
// in the system clock domain.
module spi_adc_scan #(
  parameter int CLK_DIV      = 10,
  parameter int DATA_BITS    = 12,
  parameter int LEAD_BITS    = 2,
  parameter int TRAIL_BITS   = 2,
  parameter int NUM_CH       = 2,
  parameter int CAL_CYCLES   = 32,
  parameter int QUIET_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  spi_adc_scan_if.slave bus
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_BITS + TRAIL_BITS;
  localparam int QUIET_CLKS = QUIET_CYCLES * 2 * CLK_DIV;
  localparam int MAX_BITS   = (FRAME_BITS > CAL_CYCLES) ? FRAME_BITS : CAL_CYCLES;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(MAX_BITS + 1);
  localparam int QUIET_W    = $clog2(QUIET_CLKS + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]   CAL_LAST   = BIT_W'(CAL_CYCLES - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CLKS - 1);

  typedef enum logic [1:0] {QUIET, CAL, IDLE, CONVERT} StateT;

  StateT                              r_state;
  logic [DIV_W-1:0]                   r_divCnt;
  logic [BIT_W-1:0]                   r_bitCnt;
  logic [QUIET_W-1:0]                 r_quietCnt;
  logic                               r_sclk;
  logic                               r_csN;
  logic                               r_valid;
  logic                               r_busy;
  logic                               r_cal;
  logic                               r_overrun;
  logic                               r_calPending;
  logic                               r_startPending;
  logic [NUM_CH-1:0][DATA_BITS-1:0]   r_shift;
  logic [NUM_CH*DATA_BITS-1:0]        r_data;

  logic                               w_tick;
  logic                               w_rise;
  logic                               w_inWindow;
  logic [NUM_CH-1:0][DATA_BITS-1:0]   w_shiftNext;

  assign w_tick     = (r_divCnt == DIV_LAST);
  assign w_rise     = w_tick && !r_sclk;
  assign w_inWindow = (int'(r_bitCnt) >= LEAD_BITS) &&
                      (int'(r_bitCnt) <  LEAD_BITS + DATA_BITS);

  // Next shift-register contents if the current cycle carries a data-bit rising edge
  always_comb begin
    w_shiftNext = r_shift;
    if (w_inWindow) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        w_shiftNext[ch] = (r_shift[ch] << 1) | DATA_BITS'(bus.sdo[ch]);
      end
    end
  end

  // Frame sequencer: divider, bit counting, request latching and state transitions
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= QUIET;
      r_divCnt       <= '0;
      r_bitCnt       <= '0;
      r_quietCnt     <= '0;
      r_sclk         <= 1'b1;
      r_csN          <= 1'b1;
      r_valid        <= 1'b0;
      r_busy         <= 1'b1;
      r_cal          <= 1'b0;
      r_overrun      <= 1'b0;
      r_calPending   <= 1'b1;
      r_startPending <= 1'b0;
      r_shift        <= '0;
      // A reset that interrupts a conversion keeps the last good result;
      // holding reset for more than one cycle always clears it.
      if (r_state != CONVERT) begin
        r_data <= '0;
      end
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;

      if (r_state != IDLE) begin
        if (bus.recalibrate) begin
          r_calPending <= 1'b1;
        end
        if (bus.start && !bus.cont) begin
          if (r_startPending) begin
            r_overrun <= 1'b1;
          end else begin
            r_startPending <= 1'b1;
          end
        end
      end

      if (!r_csN) begin
        if (w_tick) begin
          r_divCnt <= '0;
          r_sclk   <= ~r_sclk;
        end else begin
          r_divCnt <= r_divCnt + 1'b1;
        end
        if (w_rise) begin
          r_bitCnt <= r_bitCnt + 1'b1;
        end
      end

      case (r_state)
        QUIET: begin
          if (r_quietCnt == QUIET_LAST) begin
            r_quietCnt <= '0;
            if (r_calPending || bus.recalibrate) begin
              r_state  <= CAL;
              r_cal    <= 1'b1;
              r_csN    <= 1'b0;
              r_divCnt <= '0;
              r_bitCnt <= '0;
            end else if (r_startPending || bus.start || bus.cont) begin
              r_state        <= CONVERT;
              r_startPending <= 1'b0;
              r_csN          <= 1'b0;
              r_divCnt       <= '0;
              r_bitCnt       <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_quietCnt <= r_quietCnt + 1'b1;
          end
        end

        IDLE: begin
          if (bus.recalibrate) begin
            r_state        <= CAL;
            r_busy         <= 1'b1;
            r_cal          <= 1'b1;
            r_startPending <= bus.start && !bus.cont;
            r_csN          <= 1'b0;
            r_divCnt       <= '0;
            r_bitCnt       <= '0;
          end else if (bus.start || bus.cont) begin
            r_state  <= CONVERT;
            r_busy   <= 1'b1;
            r_csN    <= 1'b0;
            r_divCnt <= '0;
            r_bitCnt <= '0;
          end
        end

        CAL: begin
          if (w_rise && r_bitCnt == CAL_LAST) begin
            r_calPending <= 1'b0;
            r_state      <= QUIET;
            r_cal        <= 1'b0;
            r_csN        <= 1'b1;
            r_quietCnt   <= '0;
          end
        end

        CONVERT: begin
          if (w_rise) begin
            r_shift <= w_shiftNext;
          end
          if (w_rise && r_bitCnt == FRAME_LAST) begin
            r_data     <= w_shiftNext;
            r_valid    <= 1'b1;
            r_state    <= QUIET;
            r_csN      <= 1'b1;
            r_quietCnt <= '0;
          end
        end

        default: begin
          r_state <= QUIET;
          r_csN   <= 1'b1;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sclk        = r_sclk;
  assign bus.cs_n        = r_csN;
  assign bus.data        = r_data;
  assign bus.valid       = r_valid;
  assign bus.busy        = r_busy;
  assign bus.calibrating = r_cal;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_spi_adc_scan.sv
// Self-checking bench for spi_adc_scan. Behavioural ADC models shift a
// randomised (or fixed) word out on falling SCLK; a monitor records frame
// statistics; directed steps compare against values derived from the frame
// rules. Single-shot latency convention: valid is observed
// 1 + FRAME_BITS*2*CLK_DIV system clocks after the cycle carrying start.
module tb_spi_adc_scan;

  localparam int CLK_DIV      = 10;
  localparam int DATA_BITS    = 12;
  localparam int LEAD_BITS    = 2;
  localparam int TRAIL_BITS   = 2;
  localparam int NUM_CH       = 2;
  localparam int CAL_CYCLES   = 32;
  localparam int QUIET_CYCLES = 2;

  localparam int FRAME_BITS = LEAD_BITS + DATA_BITS + TRAIL_BITS;
  localparam int FRAME_CLKS = FRAME_BITS * 2 * CLK_DIV;
  localparam int CAL_CLKS   = CAL_CYCLES * 2 * CLK_DIV;
  localparam int QUIET_CLKS = QUIET_CYCLES * 2 * CLK_DIV;
  localparam int CONV_LAT   = 1 + FRAME_CLKS;

  logic clk = 1'b0;
  logic reset = 1'b1;

  spi_adc_scan_if #(.NUM_CH(NUM_CH), .DATA_BITS(DATA_BITS)) bus ();

  spi_adc_scan #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .LEAD_BITS(LEAD_BITS),
    .TRAIL_BITS(TRAIL_BITS), .NUM_CH(NUM_CH), .CAL_CYCLES(CAL_CYCLES),
    .QUIET_CYCLES(QUIET_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ADC model and frame monitor state
  logic [DATA_BITS-1:0]        adcVal [NUM_CH];
  logic [DATA_BITS-1:0]        fixedVal [NUM_CH];
  logic                        useFixed = 1'b0;
  logic [NUM_CH*DATA_BITS-1:0] curExp = '0;
  logic prevSclk = 1'b1;
  logic prevCsn = 1'b1;
  logic frameIsCal = 1'b0;
  logic lastWasCal = 1'b0;
  int fallCnt = 0, lowCycles = 0, highCycles = 0, calBad = 0;
  int lastFalls = 0, lastLow = 0, lastHigh = 0, lastCalBad = 0;
  int validCnt = 0, overrunCnt = 0;

  function automatic logic streamBit(input int ch, input int k);
    if (k < LEAD_BITS || k >= LEAD_BITS + DATA_BITS) return 1'b0;
    return adcVal[ch][DATA_BITS - 1 - (k - LEAD_BITS)];
  endfunction

  // ADC models plus frame statistics, sampled half a cycle after the DUT edge
  always @(negedge clk) begin
    if (bus.valid === 1'b1) validCnt++;
    if (bus.overrun === 1'b1) overrunCnt++;
    if (bus.cs_n === 1'b0) begin
      if (prevCsn) begin
        fallCnt = 0;
        lowCycles = 0;
        calBad = 0;
        lastHigh = highCycles;
        frameIsCal = bus.calibrating;
        if (!bus.calibrating) begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            adcVal[ch] = useFixed ? fixedVal[ch] : DATA_BITS'($urandom);
            curExp[ch*DATA_BITS +: DATA_BITS] = adcVal[ch];
          end
        end
      end
      lowCycles++;
      highCycles = 0;
      if (bus.calibrating !== frameIsCal) calBad++;
      if (prevSclk && bus.sclk === 1'b0) begin
        for (int ch = 0; ch < NUM_CH; ch++) bus.sdo[ch] = streamBit(ch, fallCnt);
        fallCnt++;
      end
    end else begin
      if (!prevCsn) begin
        lastFalls = fallCnt;
        lastLow = lowCycles;
        lastWasCal = frameIsCal;
        lastCalBad = calBad;
      end
      highCycles++;
      bus.sdo = '0;
    end
    prevCsn = bus.cs_n;
    prevSclk = bus.sclk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    bus.start = s;
    bus.recalibrate = r;
    @(negedge clk);
    bus.start = 1'b0;
    bus.recalibrate = 1'b0;
  endtask

  task automatic stepCycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.valid !== 1'b1 && n < 5000);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, bus.busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, v0, o0;
    logic [NUM_CH*DATA_BITS-1:0] goodData;
    bus.start = 1'b0;
    bus.cont = 1'b0;
    bus.recalibrate = 1'b0;
    fixedVal[0] = 12'hA5C;
    fixedVal[1] = 12'h3F1;

    // Reset values
    stepCycles(3);
    checkOutput("rst sclk", bus.sclk, 1'b1);
    checkOutput("rst cs_n", bus.cs_n, 1'b1);
    checkOutput("rst data", bus.data, '0);
    checkOutput("rst valid", bus.valid, 1'b0);
    checkOutput("rst busy", bus.busy, 1'b1);
    checkOutput("rst calibrating", bus.calibrating, 1'b0);
    checkOutput("rst overrun", bus.overrun, 1'b0);
    reset = 1'b0;

    // Power-up calibration
    waitIdle("pwr idle");
    checkOutput("pwr was cal", lastWasCal, 1'b1);
    checkOutput("pwr falls", lastFalls, CAL_CYCLES);
    checkOutput("pwr low clks", lastLow, CAL_CLKS);
    checkOutput("pwr cal steady", lastCalBad, 0);
    checkOutput("pwr no valid", validCnt, 0);

    // Single shot with fixed ADC words
    useFixed = 1'b1;
    v0 = validCnt;
    applyStimulus(1'b1, 1'b0);
    waitValid(n);
    checkOutput("ss latency", n + 1, CONV_LAT);
    checkOutput("ss data", bus.data, 24'h3F1A5C);
    waitIdle("ss idle");
    checkOutput("ss one valid", validCnt - v0, 1);
    checkOutput("ss falls", lastFalls, FRAME_BITS);
    useFixed = 1'b0;

    // Continuous mode, random words, cont dropped mid third frame
    v0 = validCnt;
    bus.cont = 1'b1;
    waitValid(n);
    checkOutput("cont lat1", n, CONV_LAT);
    checkOutput("cont data1", bus.data, curExp);
    waitValid(n);
    checkOutput("cont gap2", n, FRAME_CLKS + QUIET_CLKS);
    checkOutput("cont data2", bus.data, curExp);
    stepCycles(150);
    bus.cont = 1'b0;
    waitValid(n);
    checkOutput("cont gap3", n + 150, FRAME_CLKS + QUIET_CLKS);
    checkOutput("cont data3", bus.data, curExp);
    checkOutput("cont quiet", lastHigh >= QUIET_CLKS, 1'b1);
    stepCycles(800);
    checkOutput("cont three valid", validCnt - v0, 3);
    checkOutput("cont idle", bus.busy, 1'b0);

    // Overrun: three starts within one frame
    v0 = validCnt;
    o0 = overrunCnt;
    applyStimulus(1'b1, 1'b0);
    stepCycles(50);
    applyStimulus(1'b1, 1'b0);
    stepCycles(50);
    applyStimulus(1'b1, 1'b0);
    stepCycles(2);
    checkOutput("ovr pulse", overrunCnt - o0, 1);
    waitValid(n);
    checkOutput("ovr data1", bus.data, curExp);
    waitValid(n);
    checkOutput("ovr data2", bus.data, curExp);
    waitIdle("ovr idle");
    checkOutput("ovr two valid", validCnt - v0, 2);

    // Recalibrate coinciding with start in IDLE
    v0 = validCnt;
    applyStimulus(1'b1, 1'b1);
    checkOutput("rc calibrating", bus.calibrating, 1'b1);
    waitValid(n);
    checkOutput("rc latency", n + 1, 1 + CAL_CLKS + QUIET_CLKS + FRAME_CLKS);
    checkOutput("rc data", bus.data, curExp);
    goodData = curExp;
    waitIdle("rc idle");
    checkOutput("rc one valid", validCnt - v0, 1);

    // Reset in the middle of data bit 7
    v0 = validCnt;
    applyStimulus(1'b1, 1'b0);
    stepCycles(153);
    checkOutput("mid sclk low", bus.sclk, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid cs_n", bus.cs_n, 1'b1);
    checkOutput("mid sclk", bus.sclk, 1'b1);
    checkOutput("mid valid", bus.valid, 1'b0);
    checkOutput("mid busy", bus.busy, 1'b1);
    checkOutput("mid data kept", bus.data, goodData);
    waitIdle("mid idle");
    checkOutput("mid cal frame", lastWasCal, 1'b1);
    checkOutput("mid cal falls", lastFalls, CAL_CYCLES);
    checkOutput("mid no valid", validCnt - v0, 0);
    checkOutput("mid data final", bus.data, goodData);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
